// File: rtl/rotate_left_pipe.sv
// Pipelined left rotator with valid/ready handshakes on both sides.
// S0 registers the input word; each following stage applies one amount bit,
// and the last stage drives the output directly.
module rotate_left_pipe #(
  parameter int WIDTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(WIDTH)-1:0]   amount,
  input  logic [WIDTH-1:0]           din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           dout,
  output logic                       busy
);

  localparam int AMTW = $clog2(WIDTH);

  // Stage k data; stage AMTW is the output register.
  logic [WIDTH-1:0] data_q [0:AMTW];
  // Residual amount bits, shifted down one place per stage so that
  // stage k always consumes bit 0 of what stage k-1 carries.
  logic [AMTW-1:0]  amt_q  [0:AMTW-1];
  logic [AMTW:0]    vld_q;
  // adv[k]: stage k takes a new word (or bubble) from its upstream this cycle.
  logic [AMTW:0]    adv;
  logic [WIDTH-1:0] rot_d  [1:AMTW];

  // A stage can advance when the output drains or any stage at or after it
  // holds a bubble; written flat to avoid a chained ready path.
  genvar g;
  generate
    for (g = 0; g <= AMTW; g++) begin : g_adv
      assign adv[g] = out_ready | ~(&vld_q[AMTW:g]);
    end
  endgenerate

  // Stage k rotates left by 2^(k-1) when its residual amount bit is set.
  always_comb begin
    int s;
    s = 0;
    for (int k = 1; k <= AMTW; k++) begin
      s = 1 << (k - 1);
      rot_d[k] = amt_q[k-1][0]
               ? ((data_q[k-1] << s) | (data_q[k-1] >> (WIDTH - s)))
               : data_q[k-1];
    end
  end

  // Pipeline registers: each stage loads when allowed, otherwise holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k <= AMTW; k++) data_q[k] <= '0;
      for (int k = 0; k < AMTW; k++)  amt_q[k]  <= '0;
    end else begin
      if (adv[0]) begin
        data_q[0] <= din;
        amt_q[0]  <= amount;
        vld_q[0]  <= in_valid;
      end
      for (int k = 1; k <= AMTW; k++) begin
        if (adv[k]) begin
          data_q[k] <= rot_d[k];
          vld_q[k]  <= vld_q[k-1];
        end
      end
      for (int k = 1; k < AMTW; k++) begin
        if (adv[k]) amt_q[k] <= amt_q[k-1] >> 1;
      end
    end
  end

  assign in_ready  = ~reset & adv[0];
  assign out_valid = vld_q[AMTW];
  assign dout      = data_q[AMTW];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_rotate_left_pipe.sv
// Bench for rotate_left_pipe at WIDTH=4: directed cases plus a scoreboard
// monitor that checks every output word, its inverse, and stall stability.
module tb_rotate_left_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] amount;
  logic [3:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] dout;
  logic       busy;

  rotate_left_pipe #(.WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .amount    (amount),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] d;
    logic [1:0] a;
  } item_t;

  item_t      sb [$];
  item_t      it;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       stall_prev = 1'b0;
  logic [3:0] dout_prev  = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rotl_m(input logic [3:0] d, input int a);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[(i + a) % 4] = d[i];
    return r;
  endfunction

  function automatic logic [3:0] rotr_m(input logic [3:0] d, input int a);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = d[(i + a) % 4];
    return r;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drain;
    for (int c = 0; c < 40 && (sb.size() != 0 || busy); c++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: values at the falling edge are what the next rising edge sees.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_dout", 32'(dout), 32'(dout_prev));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("out_when_empty", 32'(out_valid), 32'd0);
        end else begin
          it = sb.pop_front();
          chk("dout", 32'(dout), 32'(rotl_m(it.d, int'(it.a))));
          chk("inverse", 32'(rotr_m(dout, int'(it.a))), 32'(it.d));
        end
      end
      if (in_valid && in_ready) sb.push_back('{d: din, a: amount});
      stall_prev = out_valid && !out_ready;
      dout_prev  = dout;
    end
  end

  logic [3:0] s_din [0:3] = '{4'b1000, 4'b0110, 4'b1011, 4'b1111};
  logic [1:0] s_amt [0:3] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] s_exp [0:3] = '{4'b0001, 4'b1001, 4'b1101, 4'b1111};
  logic [3:0] b_din [0:7] = '{4'b0011, 4'b0101, 4'b1001, 4'b0111, 4'b1110, 4'b0001, 4'b0010, 4'b0100};
  logic [1:0] b_amt [0:7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};

  initial begin
    int idx;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0; amount = '0;

    // reset state
    tick(); tick();
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // single word, latency
    tick();
    out_ready = 1'b1; in_valid = 1'b1; din = 4'b0001; amount = 2'd1;
    tick();
    in_valid = 1'b0;
    @(negedge clock); chk("lat_n0", 32'(out_valid), 32'd0);
    tick(); @(negedge clock); chk("lat_n1", 32'(out_valid), 32'd0);
    tick(); @(negedge clock); chk("lat_n2", 32'(out_valid), 32'd1);
    chk("lat_dout", 32'(dout), 32'b0010);
    tick(); @(negedge clock); chk("lat_n3", 32'(out_valid), 32'd0);

    // back-to-back stream
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; din = s_din[i]; amount = s_amt[i];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      chk("stream_valid", 32'(out_valid), 32'(i >= 3 && i < 7));
      if (i >= 3 && i < 7) chk("stream_dout", 32'(dout), 32'(s_exp[i-3]));
      tick();
    end
    drain();

    // backpressure
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; din = b_din[idx]; amount = b_amt[idx];
      @(negedge clock);
      if (in_ready && idx < 7) idx++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(idx), 32'd3);
    @(negedge clock);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_first", 32'(dout), 32'b0110);
    tick();
    out_ready = 1'b1;
    drain();

    // reset mid-flight
    tick();
    in_valid = 1'b1; din = 4'b1010; amount = 2'd1;
    tick();
    din = 4'b1100; amount = 2'd2;
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clock);
      chk("mid_rst_no_ghost", 32'(out_valid), 32'd0);
    end

    // exhaustive din x amount
    tick();
    for (int d = 0; d < 16; d++) begin
      for (int a = 0; a < 4; a++) begin
        in_valid = 1'b1; din = 4'(d); amount = 2'(a);
        tick();
      end
    end
    in_valid = 1'b0;
    drain();

    // random stalls
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      din       = 4'($urandom_range(0, 15));
      amount    = 2'($urandom_range(0, 3));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
